// File: rtl/menu_audio_pkg.sv
// menu_audio_pkg: shared defaults, sample type and helpers for the I2S receiver
package menu_audio_pkg;
  localparam int W_DEF = 16;
  localparam int TIMEOUT_DEF = 1024;
  localparam int LOCK_WORDS_DEF = 4;
  typedef logic signed [W_DEF-1:0] sample_t;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/i2s_rx_sig_filter.sv
// sig_filter: 2-flop synchronizer followed by a two-sample-agreement deglitcher
module sig_filter (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1, s2, s3;
  // synchronize, then move the filtered level only when two synced samples agree
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      q  <= (s2 == s3) ? s2 : q;
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver with filtered inputs, word validation, lock tracking and idle timeout
module i2s_rx import menu_audio_pkg::*; #(
  parameter int W = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int LOCK_WORDS = LOCK_WORDS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                ws,
  input  logic                sdata,
  output logic signed [W-1:0] left,
  output logic signed [W-1:0] right,
  output logic                l_stb,
  output logic                r_stb,
  output logic                locked,
  output logic [7:0]          err_cnt
);
  localparam int BW = $clog2(W + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(LOCK_WORDS + 1);
  logic bclk_f, ws_f, sd_f, bclk_d, ws_prev, synced, end_pend;
  logic bclk_rise, ws_chg, word_ok, timeout_hit;
  logic [W-1:0] word_buf;
  logic [BW-1:0] bit_idx;
  logic [5:0] word_len;
  logic [IW-1:0] idle;
  logic [RW-1:0] run;
  sig_filter u_bclk (.clk(clk), .reset(reset), .d(bclk),  .q(bclk_f));
  sig_filter u_ws   (.clk(clk), .reset(reset), .d(ws),    .q(ws_f));
  sig_filter u_sd   (.clk(clk), .reset(reset), .d(sdata), .q(sd_f));
  assign bclk_rise   = bclk_f & ~bclk_d;
  assign ws_chg      = ws_f != ws_prev;
  assign word_ok     = (word_len >= 6'(W)) && (word_len <= 6'd32);
  assign timeout_hit = !bclk_rise && (idle == IW'(TIMEOUT - 1));
  // capture bits on bclk rises, commit words one cycle after a ws change, track lock and idle
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_d   <= 1'b0;
      ws_prev  <= 1'b0;
      synced   <= 1'b0;
      end_pend <= 1'b0;
      word_buf <= '0;
      bit_idx  <= '0;
      word_len <= '0;
      idle     <= '0;
      run      <= '0;
      left     <= '0;
      right    <= '0;
      l_stb    <= 1'b0;
      r_stb    <= 1'b0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      bclk_d <= bclk_f;
      l_stb  <= 1'b0;
      r_stb  <= 1'b0;
      idle   <= bclk_rise ? '0 : (idle == IW'(TIMEOUT)) ? idle : idle + 1'b1;
      if (bclk_rise) begin
        ws_prev <= ws_f;
        if (!synced) begin
          synced   <= ws_chg;
          word_buf <= '0;
          bit_idx  <= '0;
          word_len <= '0;
        end else begin
          if (bit_idx < BW'(W)) begin
            word_buf[BW'(W - 1) - bit_idx] <= sd_f;
            bit_idx <= bit_idx + 1'b1;
          end
          word_len <= (word_len == 6'd63) ? word_len : word_len + 6'd1;
          end_pend <= end_pend | ws_chg;
        end
      end else if (end_pend) begin
        end_pend <= 1'b0;
        word_buf <= '0;
        bit_idx  <= '0;
        word_len <= '0;
        l_stb    <= ws_prev;
        r_stb    <= !ws_prev;
        if (word_ok || !locked) begin
          if (ws_prev) left <= word_buf;
          else right <= word_buf;
        end else begin
          left  <= '0;
          right <= '0;
        end
        if (word_ok) begin
          run    <= (run == RW'(LOCK_WORDS)) ? run : run + 1'b1;
          locked <= locked | (run >= RW'(LOCK_WORDS - 1));
        end else begin
          run     <= '0;
          locked  <= 1'b0;
          err_cnt <= sat_inc8(err_cnt);
        end
      end
      if (timeout_hit) begin
        locked   <= 1'b0;
        left     <= '0;
        right    <= '0;
        run      <= '0;
        end_pend <= 1'b0;
        synced   <= 1'b0;
      end
    end
  end
endmodule
